// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU that reuses one 1-bit slice over WIDTH clocks, LSB first.
// It accepts an operation on start_i and returns the result and flags with a single valid_o pulse.
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   start_i    request; accepted only while idle
//   src1_i     operand A, sampled on acceptance
//   src2_i     operand B, sampled on acceptance
//   ctrl_i     {A_invert, B_invert, slice_op[1:0]}, sampled on acceptance
//   result_o   result of the last completed operation
//   zero_o     result_o == 0
//   cout_o     carry out of the MSB (ADD/SUB only)
//   overflow_o signed overflow (ADD/SUB only)
//   valid_o    one-cycle pulse when result_o and the flags are updated
//   busy_o     operation in progress
module serial_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_shift;
    logic [3:0]         r_ctrl;
    logic               r_carry;
    logic               r_carry_msb;   // carry into the MSB slice
    logic               r_sum_msb;     // adder sum bit of the MSB slice

    logic               w_a;
    logic               w_b;
    logic               w_sum;
    logic               w_bit;
    logic               w_carry_next;
    logic               w_last;
    logic               w_arith;
    logic               w_slt;
    logic               w_supported;
    logic               w_less;
    logic [WIDTH-1:0]   w_shift_next;
    logic [WIDTH-1:0]   w_res_load;

    // One-bit slice operating on the current LSB of the operand shift registers
    assign w_a          = r_a[0] ^ r_ctrl[3];
    assign w_b          = r_b[0] ^ r_ctrl[2];
    assign w_sum        = w_a ^ w_b ^ r_carry;
    assign w_carry_next = (w_a & w_b) | ((w_a ^ w_b) & r_carry);

    always_comb begin
        w_bit = 1'b0;
        case (r_ctrl[1:0])
            2'b00:   w_bit = w_a & w_b;
            2'b01:   w_bit = w_a | w_b;
            2'b10:   w_bit = w_sum;
            default: w_bit = 1'b0;   // LESS contributes 0 until FIX
        endcase
    end

    assign w_shift_next = {w_bit, r_shift[WIDTH-1:1]};
    assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));

    assign w_arith     = (r_ctrl == 4'b0010) || (r_ctrl == 4'b0110);
    assign w_slt       = (r_ctrl == 4'b0111);
    assign w_supported = (r_ctrl == 4'b0000) || (r_ctrl == 4'b0001) || w_arith
                       || w_slt || (r_ctrl == 4'b1100);
    assign w_res_load  = w_supported ? w_shift_next : '0;

    // Signed less-than: sign of A-B corrected by the subtraction's overflow
    assign w_less = r_sum_msb ^ (r_carry_msb ^ r_carry);

    // Control FSM and datapath with registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_shift     <= '0;
            r_ctrl      <= '0;
            r_carry     <= 1'b0;
            r_carry_msb <= 1'b0;
            r_sum_msb   <= 1'b0;
            result_o    <= '0;
            zero_o      <= 1'b0;
            cout_o      <= 1'b0;
            overflow_o  <= 1'b0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_a     <= src1_i;
                        r_b     <= src2_i;
                        r_ctrl  <= ctrl_i;
                        r_carry <= ctrl_i[2];
                        r_cnt   <= '0;
                        r_shift <= '0;
                        busy_o  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_shift <= w_shift_next;
                    r_carry <= w_carry_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_carry_msb <= r_carry;
                        r_sum_msb   <= w_sum;
                        if (w_slt) begin
                            r_state <= S_FIX;
                        end else begin
                            result_o   <= w_res_load;
                            zero_o     <= (w_res_load == '0);
                            cout_o     <= w_arith & w_carry_next;
                            overflow_o <= w_arith & (r_carry ^ w_carry_next);
                            valid_o    <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_FIX: begin
                    result_o   <= WIDTH'(w_less);
                    zero_o     <= ~w_less;
                    cout_o     <= 1'b0;
                    overflow_o <= 1'b0;
                    valid_o    <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed test of serial_alu against a transaction-level reference model.
module tb_serial_alu;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic [3:0]   ctrl;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         cout_o;
    logic         overflow_o;
    logic         valid_o;
    logic         busy_o;

    serial_alu #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .src1_i     (src1),
        .src2_i     (src2),
        .ctrl_i     (ctrl),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        logic         slt;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   m_pend = 0;
    int   m_due  = 0;
    exp_t m_next;
    exp_t m_held;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: actual %h required %h", name, cyc, act, req);
        end
    endtask

    // Reference behaviour from plain arithmetic on whole words
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        exp_t     e;
        logic [W:0] s;
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.slt = 1'b0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b0010: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'b0110: begin
                s     = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'b0111: begin
                e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
                e.slt = 1'b1;
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Model timeline: acceptance, completion cycle and held outputs
    initial begin
        m_held = '{res: '0, z: 1'b0, c: 1'b0, v: 1'b0, slt: 1'b0};
        m_next = m_held;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst) begin
                m_pend = 0;
                m_held = '{res: '0, z: 1'b0, c: 1'b0, v: 1'b0, slt: 1'b0};
            end else begin
                if (m_pend && cyc == m_due) m_held = m_next;
                if (start && (!m_pend || cyc >= m_due + 2)) begin
                    m_next = model(src1, src2, ctrl);
                    m_due  = cyc + int'(W) + (m_next.slt ? 1 : 0);
                    m_pend = 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("valid_o", W'(valid_o), W'(m_pend && cyc == m_due));
            check("busy_o", W'(busy_o), W'(m_pend && cyc <= m_due));
            check("result_o", result_o, m_held.res);
            check("zero_o", W'(zero_o), W'(m_held.z));
            check("cout_o", W'(cout_o), W'(m_held.c));
            check("overflow_o", W'(overflow_o), W'(m_held.v));
        end
    end

    // Issue one operation, optionally re-pulse start mid-run, and check literal results
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op, input logic [W-1:0] er, input logic ez,
                          input logic ec, input logic ev, input int elat, input int inj);
        int acc;
        int lat;
        bit seen;
        @(negedge clk);
        src1 = a; src2 = b; ctrl = op; start = 1'b1;
        acc  = cyc + 1;
        seen = 0;
        lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            start = (inj != 0 && k == inj);
            if (k == 1) begin
                src1 = 32'hDEADBEEF; src2 = 32'h13572468; ctrl = 4'b0001;
            end
            if (start) begin
                src1 = ~a; src2 = 32'h55; ctrl = 4'b0110;
            end
            if (valid_o) begin
                seen = 1;
                lat  = cyc - acc + 1;
            end
        end
        start = 1'b0;
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: valid_o timeout, actual none required within 40 cycles", name);
        end else begin
            check({name, " latency"}, W'(lat), W'(elat));
            check({name, " result"}, result_o, er);
            check({name, " zero"}, W'(zero_o), W'(ez));
            check({name, " cout"}, W'(cout_o), W'(ec));
            check({name, " overflow"}, W'(overflow_o), W'(ev));
        end
    endtask

    initial begin
        int nvalid;
        rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; ctrl = '0;
        repeat (3) @(negedge clk);
        check("reset result", result_o, 32'h0);
        check("reset busy", W'(busy_o), 32'h0);
        check("reset valid", W'(valid_o), 32'h0);
        rst = 1'b0;

        run_op("ADD ovf", 32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1, 33, 0);
        run_op("SUB eq",  32'h00000005, 32'h00000005, 4'b0110, 32'h00000000, 1'b1, 1'b1, 1'b0, 33, 0);
        run_op("SLT -1<1", 32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 1'b0, 1'b0, 1'b0, 34, 0);
        run_op("SLT min<max", 32'h80000000, 32'h7FFFFFFF, 4'b0111, 32'h00000001, 1'b0, 1'b0, 1'b0, 34, 0);
        run_op("SLT 3<-2", 32'h00000003, 32'hFFFFFFFE, 4'b0111, 32'h00000000, 1'b1, 1'b0, 1'b0, 34, 0);
        run_op("AND", 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 33, 0);
        run_op("OR",  32'hF0F0F0F0, 32'h0FF00FF0, 4'b0001, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 33, 0);
        run_op("NOR", 32'h00000000, 32'h00000000, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 33, 0);
        run_op("ADD carry", 32'hFFFFFFFF, 32'h00000002, 4'b0010, 32'h00000001, 1'b0, 1'b1, 1'b0, 33, 0);
        run_op("BAD op", 32'h12345678, 32'h9ABCDEF0, 4'b0011, 32'h00000000, 1'b1, 1'b0, 1'b0, 33, 0);
        run_op("ADD ignore", 32'h00000001, 32'h00000002, 4'b0010, 32'h00000003, 1'b0, 1'b0, 1'b0, 33, 10);
        run_op("ADD b2b", 32'h00000010, 32'h00000020, 4'b0010, 32'h00000030, 1'b0, 1'b0, 1'b0, 33, 0);

        // Reset mid-operation aborts without a valid pulse
        @(negedge clk);
        src1 = 32'h0000000A; src2 = 32'h00000014; ctrl = 4'b0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", W'(busy_o), 32'h0);
        check("abort valid", W'(valid_o), 32'h0);
        check("abort result", result_o, 32'h0);
        check("abort zero", W'(zero_o), 32'h0);
        check("abort flags", W'({cout_o, overflow_o}), 32'h0);
        rst = 1'b0;
        nvalid = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid_o) nvalid++;
        end
        check("abort no valid", W'(nvalid), 32'h0);
        run_op("ADD after rst", 32'h12345678, 32'h11111111, 4'b0010, 32'h23456789, 1'b0, 1'b0, 1'b0, 33, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
